// File: rtl/sand_write_arbiter_if.sv
// Bus bundle for the sand display write arbiter: the Avalon host write port,
// the physics engine request port, the vblank qualifier and the registered
// write port into the display register file.
//
// Handshakes:
//   host   : a write is taken on a rising edge where chipselect && write && !waitrequest.
//            While waitrequest is high the host holds address/writedata/write.
//   engine : eng_req is held with stable eng_address/eng_writedata until eng_ack
//            pulses for one cycle; the write is issued on that same edge.
//   output : out_write is a one-cycle strobe qualifying out_address/out_writedata.
interface sand_write_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) ();
    logic              chipselect;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;

    logic              eng_req;
    logic [ADDR_W-1:0] eng_address;
    logic [DATA_W-1:0] eng_writedata;
    logic              eng_ack;

    logic              vblank;

    logic              out_write;
    logic [ADDR_W-1:0] out_address;
    logic [DATA_W-1:0] out_writedata;
    logic [CNT_W-1:0]  fifo_count;

    // Arbiter side
    modport slave (
        input  chipselect, write, address, writedata,
        input  eng_req, eng_address, eng_writedata,
        input  vblank,
        output waitrequest, eng_ack,
        output out_write, out_address, out_writedata, fifo_count
    );

    // Driver side (host, engine and video timing as seen by the arbiter)
    modport master (
        output chipselect, write, address, writedata,
        output eng_req, eng_address, eng_writedata,
        output vblank,
        input  waitrequest, eng_ack,
        input  out_write, out_address, out_writedata, fifo_count
    );
endinterface

// File: rtl/sand_write_arbiter.sv
// Single write port into the sand display register file. Host writes are
// queued in a small FIFO and compete round-robin with the physics engine;
// grants happen only while vblank is high so a frame is never torn.
module sand_write_arbiter #(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sand_write_arbiter_if.slave  bus
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // Which source received the most recent grant.
    typedef enum logic {
        SRC_HOST   = 1'b0,
        SRC_ENGINE = 1'b1
    } src_e;

    logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    src_e               last_grant_q, last_grant_d;
    logic               out_write_q, out_write_d;
    logic [ADDR_W-1:0]  out_address_q, out_address_d;
    logic [DATA_W-1:0]  out_writedata_q, out_writedata_d;
    logic               eng_ack_q, eng_ack_d;

    logic               full;
    logic               push;
    logic               pop;
    logic               host_pend;
    logic               eng_pend;
    logic               grant_host;
    logic               grant_eng;
    logic [ENTRY_W-1:0] head;

    assign full      = (count_q == FULL_COUNT);
    assign push      = bus.chipselect && bus.write && !full;
    // Registered count: an entry pushed this cycle only competes from the next one.
    assign host_pend = (count_q != '0);
    // The ack cycle never re-grants the engine, whatever eng_req shows.
    assign eng_pend  = bus.eng_req && !eng_ack_q;
    assign head      = fifo_mem_q[rd_ptr_q];
    assign pop       = grant_host;

    // Source selection: vblank-qualified, round-robin under contention.
    always_comb begin
        grant_host = 1'b0;
        grant_eng  = 1'b0;
        if (bus.vblank) begin
            if (host_pend && eng_pend) begin
                if (last_grant_q == SRC_ENGINE) begin
                    grant_host = 1'b1;
                end else begin
                    grant_eng = 1'b1;
                end
            end else if (host_pend) begin
                grant_host = 1'b1;
            end else if (eng_pend) begin
                grant_eng = 1'b1;
            end
        end
    end

    // Next state for FIFO bookkeeping, round-robin pointer and the write port.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        last_grant_d    = last_grant_q;
        out_write_d     = 1'b0;
        out_address_d   = out_address_q;
        out_writedata_d = out_writedata_q;
        eng_ack_d       = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (grant_host) begin
            out_write_d     = 1'b1;
            out_address_d   = head[ENTRY_W-1:DATA_W];
            out_writedata_d = head[DATA_W-1:0];
            last_grant_d    = SRC_HOST;
        end else if (grant_eng) begin
            out_write_d     = 1'b1;
            out_address_d   = bus.eng_address;
            out_writedata_d = bus.eng_writedata;
            eng_ack_d       = 1'b1;
            last_grant_d    = SRC_ENGINE;
        end
    end

    // Control and output registers; reset drops any queued or in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            last_grant_q    <= SRC_ENGINE;
            out_write_q     <= 1'b0;
            out_address_q   <= '0;
            out_writedata_q <= '0;
            eng_ack_q       <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            last_grant_q    <= last_grant_d;
            out_write_q     <= out_write_d;
            out_address_q   <= out_address_d;
            out_writedata_q <= out_writedata_d;
            eng_ack_q       <= eng_ack_d;
        end
    end

    // FIFO storage; contents are meaningless once the count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {bus.address, bus.writedata};
        end
    end

    assign bus.waitrequest   = full;
    assign bus.eng_ack       = eng_ack_q;
    assign bus.out_write     = out_write_q;
    assign bus.out_address   = out_address_q;
    assign bus.out_writedata = out_writedata_q;
    assign bus.fifo_count    = count_q;
endmodule

// File: tb/tb_sand_write_arbiter.sv
// Directed bench for sand_write_arbiter: a vector table walked one clock per
// entry, plus hand-written reset sequences.
module tb_sand_write_arbiter;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    logic clk;
    logic reset;

    sand_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus_if ();

    sand_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              h;      // chipselect && write
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              er;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic              vb;
        logic              e_ow;
        logic [ADDR_W-1:0] e_oa;
        logic [DATA_W-1:0] e_od;
        logic              e_ack;
        logic [CNT_W-1:0]  e_cnt;
        logic              e_wr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ---------------- helpers ----------------
    task automatic add(input logic h, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic er, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                       input logic vb, input logic ow, input logic [ADDR_W-1:0] oa,
                       input logic [DATA_W-1:0] od, input logic ack, input logic [CNT_W-1:0] cnt,
                       input logic wr);
        vec_t v;
        v.h = h; v.a = a; v.d = d; v.er = er; v.ea = ea; v.ed = ed; v.vb = vb;
        v.e_ow = ow; v.e_oa = oa; v.e_od = od; v.e_ack = ack; v.e_cnt = cnt; v.e_wr = wr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic er, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                         input logic vb);
        bus_if.chipselect    = h;
        bus_if.write         = h;
        bus_if.address       = a;
        bus_if.writedata     = d;
        bus_if.eng_req       = er;
        bus_if.eng_address   = ea;
        bus_if.eng_writedata = ed;
        bus_if.vblank        = vb;
    endtask

    task automatic check_all(input string tag, input logic ow, input logic [ADDR_W-1:0] oa,
                             input logic [DATA_W-1:0] od, input logic ack,
                             input logic [CNT_W-1:0] cnt, input logic wr);
        check({tag, " out_write"},     32'(bus_if.out_write),     32'(ow));
        check({tag, " out_address"},   32'(bus_if.out_address),   32'(oa));
        check({tag, " out_writedata"}, 32'(bus_if.out_writedata), 32'(od));
        check({tag, " eng_ack"},       32'(bus_if.eng_ack),       32'(ack));
        check({tag, " fifo_count"},    32'(bus_if.fifo_count),    32'(cnt));
        check({tag, " waitrequest"},   32'(bus_if.waitrequest),   32'(wr));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //   h  a  d      er ea ed     vb   ow oa od     ack cnt wr
        // Host ordering: fill with vblank low, stall a 5th write, then drain.
        add(1, 0, 'h10,  0, 0, 'h00,  0,   0, 0, 'h00,  0,  1, 0);
        add(1, 1, 'h11,  0, 0, 'h00,  0,   0, 0, 'h00,  0,  2, 0);
        add(1, 2, 'h12,  0, 0, 'h00,  0,   0, 0, 'h00,  0,  3, 0);
        add(1, 3, 'h13,  0, 0, 'h00,  0,   0, 0, 'h00,  0,  4, 1);
        add(1, 4, 'h14,  0, 0, 'h00,  0,   0, 0, 'h00,  0,  4, 1);
        add(1, 4, 'h14,  0, 0, 'h00,  1,   1, 0, 'h10,  0,  3, 0);
        add(1, 4, 'h14,  0, 0, 'h00,  1,   1, 1, 'h11,  0,  3, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   1, 2, 'h12,  0,  2, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   1, 3, 'h13,  0,  1, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   1, 4, 'h14,  0,  0, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   0, 4, 'h14,  0,  0, 0);
        // Engine latency and no double issue in the ack cycle.
        add(0, 0, 'h00,  1, 3, 'h40,  1,   1, 3, 'h40,  1,  0, 0);
        add(0, 0, 'h00,  1, 3, 'h40,  1,   0, 3, 'h40,  0,  0, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   0, 3, 'h40,  0,  0, 0);
        // Round-robin: 3 host entries vs a continuously requesting engine.
        add(1, 5, 'h21,  1, 6, 'h50,  0,   0, 3, 'h40,  0,  1, 0);
        add(1, 6, 'h22,  1, 6, 'h50,  0,   0, 3, 'h40,  0,  2, 0);
        add(1, 7, 'h23,  1, 6, 'h50,  0,   0, 3, 'h40,  0,  3, 0);
        add(0, 0, 'h00,  1, 6, 'h50,  1,   1, 5, 'h21,  0,  2, 0);
        add(0, 0, 'h00,  1, 6, 'h50,  1,   1, 6, 'h50,  1,  2, 0);
        add(0, 0, 'h00,  1, 6, 'h50,  1,   1, 6, 'h22,  0,  1, 0);
        add(0, 0, 'h00,  1, 6, 'h51,  1,   1, 6, 'h51,  1,  1, 0);
        add(0, 0, 'h00,  1, 6, 'h51,  1,   1, 7, 'h23,  0,  0, 0);
        add(0, 0, 'h00,  1, 2, 'h52,  1,   1, 2, 'h52,  1,  0, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   0, 2, 'h52,  0,  0, 0);
        // vblank gating: one trailing write, then hold until vblank returns.
        add(1, 1, 'h31,  1, 4, 'h60,  0,   0, 2, 'h52,  0,  1, 0);
        add(1, 2, 'h32,  1, 4, 'h60,  0,   0, 2, 'h52,  0,  2, 0);
        add(0, 0, 'h00,  1, 4, 'h60,  1,   1, 1, 'h31,  0,  1, 0);
        add(0, 0, 'h00,  1, 4, 'h60,  0,   0, 1, 'h31,  0,  1, 0);
        add(0, 0, 'h00,  1, 4, 'h60,  0,   0, 1, 'h31,  0,  1, 0);
        add(0, 0, 'h00,  1, 4, 'h60,  1,   1, 4, 'h60,  1,  1, 0);
        add(0, 0, 'h00,  1, 4, 'h60,  1,   1, 2, 'h32,  0,  0, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   0, 2, 'h32,  0,  0, 0);
        // Push and pop together at count 3, with pointers wrapping.
        add(1, 3, 'h71,  0, 0, 'h00,  0,   0, 2, 'h32,  0,  1, 0);
        add(1, 4, 'h72,  0, 0, 'h00,  0,   0, 2, 'h32,  0,  2, 0);
        add(1, 5, 'h73,  0, 0, 'h00,  0,   0, 2, 'h32,  0,  3, 0);
        add(1, 6, 'h74,  0, 0, 'h00,  1,   1, 3, 'h71,  0,  3, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   1, 4, 'h72,  0,  2, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   1, 5, 'h73,  0,  1, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   1, 6, 'h74,  0,  0, 0);
        add(0, 0, 'h00,  0, 0, 'h00,  1,   0, 6, 'h74,  0,  0, 0);

        // Reset defaults: hold reset for 3 cycles.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", 0, 0, 'h00, 0, 0, 0);
        reset = 1'b0;

        // Table: inputs applied at negedge, outputs checked at the next negedge.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].h, vecs[i].a, vecs[i].d, vecs[i].er, vecs[i].ea, vecs[i].ed, vecs[i].vb);
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].e_ow, vecs[i].e_oa, vecs[i].e_od,
                      vecs[i].e_ack, vecs[i].e_cnt, vecs[i].e_wr);
        end

        // Mid-burst reset: two entries queued, one write in flight.
        drive(1, 1, 'h81, 0, 0, 0, 0);
        @(posedge clk); @(negedge clk);
        drive(1, 2, 'h82, 0, 0, 0, 0);
        @(posedge clk); @(negedge clk);
        check("midrst queued count", 32'(bus_if.fifo_count), 32'd2);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); @(negedge clk);
        check("midrst inflight write", 32'(bus_if.out_write), 32'd1);
        check("midrst inflight addr",  32'(bus_if.out_address), 32'd1);
        check("midrst count before",   32'(bus_if.fifo_count), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst async out_write",   32'(bus_if.out_write), 32'd0);
        check("midrst async fifo_count",  32'(bus_if.fifo_count), 32'd0);
        check("midrst async out_address", 32'(bus_if.out_address), 32'd0);
        check("midrst async waitrequest", 32'(bus_if.waitrequest), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("postrst%0d out_write", i),  32'(bus_if.out_write), 32'd0);
            check($sformatf("postrst%0d fifo_count", i), 32'(bus_if.fifo_count), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sand_write_arbiter.md
# sand_write_arbiter

Schedules all writes into the sand display register file: background colour and ball position, 3-bit address, 8-bit data. Buffers Avalon host writes in a small FIFO. Arbitrates them round-robin against the on-chip physics engine's write requests. Issues at most one write per cycle on a single registered write port, and only while the display is in vertical blank, so register updates never tear a frame.

## Interface
- ADDR_W, 3, register address width
- DATA_W, 8, register data width
- FIFO_DEPTH, 4, host write FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- chipselect  in  1  Avalon host select
- write  in  1  Avalon host write strobe
- address  in  ADDR_W  host register address
- writedata  in  DATA_W  host write data
- waitrequest  out  1  high when the FIFO is full; combinational from registered count
- eng_req  in  1  engine write request; held until eng_ack
- eng_address  in  ADDR_W  engine address; stable while eng_req is high
- eng_writedata  in  DATA_W  engine data; stable while eng_req is high
- eng_ack  out  1  one-cycle pulse when the engine write is issued
- vblank  in  1  high during vertical blank; writes are granted only when high
- out_write  out  1  registered write strobe to the register file
- out_address  out  ADDR_W  registered write address
- out_writedata  out  DATA_W  registered write data
- fifo_count  out  clog2(FIFO_DEPTH)+1  host entries pending

## Operation
- Reset values: out_write=0, out_address=0, out_writedata=0, eng_ack=0, fifo_count=0, waitrequest=0. Round-robin pointer last_grant=ENGINE, so the host wins the first contention. Pending FIFO contents are discarded.
- **Host accept:** when chipselect && write && !waitrequest, push {address, writedata} at the tail. Writes while waitrequest=1 are not accepted; the host must hold them.
- **Pending sources:**
  - Host: pending when fifo_count>0, using the registered count, so an entry pushed this cycle is not eligible until the next cycle.
  - Engine: pending when eng_req=1 && eng_ack=0. The cycle carrying eng_ack never re-grants the engine, which prevents a double issue.
- **Grant (only when vblank=1 in the current cycle):**
  - Exactly one source pending: grant it.
  - Both pending: grant the source opposite to last_grant, then update last_grant.
  - None pending: no grant; out_write=0 next cycle.
- **Issue:**
  - On grant, load the out_* registers next edge with out_write=1.
  - Host grant: pop the FIFO head the same edge.
  - Engine grant: eng_ack=1 the same edge as out_write.
- vblank=0: no grants. Pending host entries and engine requests are held indefinitely, with no loss or reordering.
- Host writes are issued in FIFO order. Order between host and engine is defined only by grant order.
- Push and pop in the same cycle leave fifo_count unchanged. A push at fifo_count=FIFO_DEPTH-1 with a simultaneous pop is legal; waitrequest stays low next cycle.
- Pointers wrap modulo FIFO_DEPTH, and fifo_count saturates logically at FIFO_DEPTH because waitrequest blocks further pushes.
- Reset asserted mid-operation: an in-flight out_write is cleared immediately (async), all FIFO entries are dropped, and the engine must re-present its request after reset.

## Timing
- **Engine latency:** eng_req high and vblank high in cycle N → out_write and eng_ack high in cycle N+1.
- **Host latency:** write accepted in cycle N with empty FIFO and vblank high → out_write in cycle N+2.
- **Throughput:** one write per cycle during vblank. Under continuous contention, host and engine alternate.
- **vblank boundary:** a write granted in the last vblank cycle appears on out_write one cycle after vblank falls. The register file tolerates this single trailing write.
- waitrequest reflects fifo_count==FIFO_DEPTH with no added registering.

## Test plan
- **Reset defaults:** assert reset for 3 cycles → all outputs 0, fifo_count=0, waitrequest=0. Assert reset mid-burst with 2 entries queued → fifo_count=0 immediately, no out_write afterwards.
- **Host ordering:**
  - Stimulus: vblank=0; host writes addr 0..3 with data 8'h10..8'h13.
  - Check during vblank=0: fifo_count=4, waitrequest=1, a 5th write is stalled.
  - Raise vblank: out_write on 4 consecutive cycles, addresses 0,1,2,3 in order. waitrequest drops the cycle after the first pop.
- **Engine latency:** vblank=1, FIFO empty, eng_req with addr 3'h3, data 8'h40 at cycle N → out_write, eng_ack at N+1 with out_address=3, out_writedata=8'h40. No second issue while eng_req is still high during the eng_ack cycle.
- **Round-robin:**
  - Stimulus: FIFO holds 3 host writes and the engine requests continuously; raise vblank.
  - Required issue order: host, engine, host, engine, host.
- **vblank gating:** drop vblank while host and engine are both pending → at most one trailing out_write, then none until vblank returns. All pending writes are later issued with no loss.
- **Full boundary:** fifo_count=3, one host push and one pop in the same cycle → fifo_count stays 3, waitrequest stays 0, and data order is preserved across pointer wrap.
